// File: rtl/axi4lite_dist.sv
// AXI4-Lite 1-to-4 address-decoding distributor.
// One upstream AXI4-Lite slave port fans out to four target master ports.
// The read and write paths are independent, and each allows one outstanding transaction.
// Addresses whose top nibble is not BASE_HI, or whose select field is 4..15,
// are answered locally with DECERR and never reach a target.
module axi4lite_dist #(
   parameter logic [3:0]  BASE_HI = 4'h9,
   parameter int unsigned SEL_LO  = 24
) (
   input  logic           clk_i,
   input  logic           rst_i,
   // upstream write address / data / response
   input  logic           inport_awvalid_i,
   output logic           inport_awready_o,
   input  logic [31:0]    inport_awaddr_i,
   input  logic           inport_wvalid_i,
   output logic           inport_wready_o,
   input  logic [31:0]    inport_wdata_i,
   input  logic [3:0]     inport_wstrb_i,
   output logic           inport_bvalid_o,
   input  logic           inport_bready_i,
   output logic [1:0]     inport_bresp_o,
   // upstream read address / data
   input  logic           inport_arvalid_i,
   output logic           inport_arready_o,
   input  logic [31:0]    inport_araddr_i,
   output logic           inport_rvalid_o,
   input  logic           inport_rready_i,
   output logic [31:0]    inport_rdata_o,
   output logic [1:0]     inport_rresp_o,
   // per-target handshakes, bit n = target n
   output logic [3:0]     outport_awvalid_o,
   input  logic [3:0]     outport_awready_i,
   output logic [3:0]     outport_wvalid_o,
   input  logic [3:0]     outport_wready_i,
   input  logic [3:0]     outport_bvalid_i,
   output logic [3:0]     outport_bready_o,
   input  logic [7:0]     outport_bresp_i,
   output logic [3:0]     outport_arvalid_o,
   input  logic [3:0]     outport_arready_i,
   input  logic [3:0]     outport_rvalid_i,
   output logic [3:0]     outport_rready_o,
   input  logic [127:0]   outport_rdata_i,
   input  logic [7:0]     outport_rresp_i,
   // shared payload buses, broadcast to every target
   output logic [31:0]    outport_awaddr_o,
   output logic [31:0]    outport_wdata_o,
   output logic [3:0]     outport_wstrb_o,
   output logic [31:0]    outport_araddr_o
);

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_REQ  = 2'd1,
      W_WAIT = 2'd2,
      W_RESP = 2'd3
   } wstate_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_REQ  = 2'd1,
      R_WAIT = 2'd2,
      R_RESP = 2'd3
   } rstate_e;

   // An address is mapped when its top nibble matches and the select field is below 4.
   function automatic logic is_mapped(input logic [31:0] addr);
      return (addr[31:28] == BASE_HI) && (addr[SEL_LO +: 4] < 4'd4);
   endfunction

   // Target index; only meaningful for mapped addresses, where the upper two select bits are zero.
   function automatic logic [1:0] sel_target(input logic [31:0] addr);
      return addr[SEL_LO +: 2];
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] t);
      return 4'b0001 << t;
   endfunction

   // ---------------- write path state ----------------
   wstate_e     wstate_q, wstate_d;
   logic        w_acc_q, w_acc_d;        // one-cycle awready/wready pulse
   logic [31:0] awaddr_q, awaddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [1:0]  wtgt_q, wtgt_d;
   logic [3:0]  awv_q, awv_d;
   logic [3:0]  wv_q, wv_d;
   logic [3:0]  bready_q, bready_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;

   // ---------------- read path state ----------------
   rstate_e     rstate_q, rstate_d;
   logic        r_acc_q, r_acc_d;        // one-cycle arready pulse
   logic [31:0] araddr_q, araddr_d;
   logic [1:0]  rtgt_q, rtgt_d;
   logic [3:0]  arv_q, arv_d;
   logic [3:0]  rready_q, rready_d;
   logic        rvalid_q, rvalid_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d;

   // Write FSM next state: accept AW+W together, forward them to the target, and return its B response.
   always_comb begin
      wstate_d = wstate_q;
      w_acc_d  = 1'b0;
      awaddr_d = awaddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      wtgt_d   = wtgt_q;
      awv_d    = awv_q;
      wv_d     = wv_q;
      bready_d = bready_q;
      bvalid_d = bvalid_q;
      bresp_d  = bresp_q;
      case (wstate_q)
         W_IDLE: begin
            if (inport_awvalid_i && inport_wvalid_i) begin
               w_acc_d = 1'b1;
               if (is_mapped(inport_awaddr_i)) begin
                  awaddr_d = inport_awaddr_i;
                  wdata_d  = inport_wdata_i;
                  wstrb_d  = inport_wstrb_i;
                  wtgt_d   = sel_target(inport_awaddr_i);
                  wstate_d = W_REQ;
               end else begin
                  bresp_d  = 2'b11;
                  wstate_d = W_RESP;
               end
            end else begin
               wstate_d = W_IDLE;
            end
         end
         W_REQ: begin
            // The first cycle in W_REQ is the upstream accept cycle; the target valids launch from it.
            if (w_acc_q) begin
               awv_d = onehot(wtgt_q);
               wv_d  = onehot(wtgt_q);
            end else begin
               awv_d = awv_q & ~outport_awready_i;
               wv_d  = wv_q & ~outport_wready_i;
               if ((awv_d == 4'b0000) && (wv_d == 4'b0000)) begin
                  bready_d = onehot(wtgt_q);
                  wstate_d = W_WAIT;
               end else begin
                  wstate_d = W_REQ;
               end
            end
         end
         W_WAIT: begin
            if ((outport_bvalid_i & bready_q) != 4'b0000) begin
               bresp_d  = outport_bresp_i[{wtgt_q, 1'b0} +: 2];
               bready_d = 4'b0000;
               bvalid_d = 1'b1;
               wstate_d = W_RESP;
            end else begin
               wstate_d = W_WAIT;
            end
         end
         W_RESP: begin
            // The DECERR path arrives here with bvalid low, so it is raised one cycle after the accept.
            if (!bvalid_q) begin
               bvalid_d = 1'b1;
            end else if (inport_bready_i) begin
               bvalid_d = 1'b0;
               wstate_d = W_IDLE;
            end else begin
               bvalid_d = 1'b1;
            end
         end
         default: begin
            wstate_d = W_IDLE;
         end
      endcase
   end

   // Read FSM next state: accept AR, forward it to the target, and return its R data and response.
   always_comb begin
      rstate_d = rstate_q;
      r_acc_d  = 1'b0;
      araddr_d = araddr_q;
      rtgt_d   = rtgt_q;
      arv_d    = arv_q;
      rready_d = rready_q;
      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      case (rstate_q)
         R_IDLE: begin
            if (inport_arvalid_i) begin
               r_acc_d = 1'b1;
               if (is_mapped(inport_araddr_i)) begin
                  araddr_d = inport_araddr_i;
                  rtgt_d   = sel_target(inport_araddr_i);
                  rstate_d = R_REQ;
               end else begin
                  rresp_d  = 2'b11;
                  rdata_d  = 32'h0000_0000;
                  rstate_d = R_RESP;
               end
            end else begin
               rstate_d = R_IDLE;
            end
         end
         R_REQ: begin
            if (r_acc_q) begin
               arv_d = onehot(rtgt_q);
            end else begin
               arv_d = arv_q & ~outport_arready_i;
               if (arv_d == 4'b0000) begin
                  rready_d = onehot(rtgt_q);
                  rstate_d = R_WAIT;
               end else begin
                  rstate_d = R_REQ;
               end
            end
         end
         R_WAIT: begin
            if ((outport_rvalid_i & rready_q) != 4'b0000) begin
               rdata_d  = outport_rdata_i[{rtgt_q, 5'b00000} +: 32];
               rresp_d  = outport_rresp_i[{rtgt_q, 1'b0} +: 2];
               rready_d = 4'b0000;
               rvalid_d = 1'b1;
               rstate_d = R_RESP;
            end else begin
               rstate_d = R_WAIT;
            end
         end
         R_RESP: begin
            if (!rvalid_q) begin
               rvalid_d = 1'b1;
            end else if (inport_rready_i) begin
               rvalid_d = 1'b0;
               rstate_d = R_IDLE;
            end else begin
               rvalid_d = 1'b1;
            end
         end
         default: begin
            rstate_d = R_IDLE;
         end
      endcase
   end

   // Write path registers; reset drops any in-flight write without a response.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wstate_q <= W_IDLE;
         w_acc_q  <= 1'b0;
         awaddr_q <= 32'h0000_0000;
         wdata_q  <= 32'h0000_0000;
         wstrb_q  <= 4'h0;
         wtgt_q   <= 2'd0;
         awv_q    <= 4'b0000;
         wv_q     <= 4'b0000;
         bready_q <= 4'b0000;
         bvalid_q <= 1'b0;
         bresp_q  <= 2'b00;
      end else begin
         wstate_q <= wstate_d;
         w_acc_q  <= w_acc_d;
         awaddr_q <= awaddr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         wtgt_q   <= wtgt_d;
         awv_q    <= awv_d;
         wv_q     <= wv_d;
         bready_q <= bready_d;
         bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;
      end
   end

   // Read path registers; reset drops any in-flight read without a response.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rstate_q <= R_IDLE;
         r_acc_q  <= 1'b0;
         araddr_q <= 32'h0000_0000;
         rtgt_q   <= 2'd0;
         arv_q    <= 4'b0000;
         rready_q <= 4'b0000;
         rvalid_q <= 1'b0;
         rresp_q  <= 2'b00;
         rdata_q  <= 32'h0000_0000;
      end else begin
         rstate_q <= rstate_d;
         r_acc_q  <= r_acc_d;
         araddr_q <= araddr_d;
         rtgt_q   <= rtgt_d;
         arv_q    <= arv_d;
         rready_q <= rready_d;
         rvalid_q <= rvalid_d;
         rresp_q  <= rresp_d;
         rdata_q  <= rdata_d;
      end
   end

   // Every output comes straight from a flop.
   assign inport_awready_o  = w_acc_q;
   assign inport_wready_o   = w_acc_q;
   assign inport_bvalid_o   = bvalid_q;
   assign inport_bresp_o    = bresp_q;
   assign inport_arready_o  = r_acc_q;
   assign inport_rvalid_o   = rvalid_q;
   assign inport_rdata_o    = rdata_q;
   assign inport_rresp_o    = rresp_q;
   assign outport_awvalid_o = awv_q;
   assign outport_wvalid_o  = wv_q;
   assign outport_bready_o  = bready_q;
   assign outport_arvalid_o = arv_q;
   assign outport_rready_o  = rready_q;
   assign outport_awaddr_o  = awaddr_q;
   assign outport_wdata_o   = wdata_q;
   assign outport_wstrb_o   = wstrb_q;
   assign outport_araddr_o  = araddr_q;

endmodule

// File: tb/tb_axi4lite_dist.sv
// Directed testbench for axi4lite_dist.
// The bench drives the upstream master side. It also runs a small target
// responder with a configurable W-ready delay and with configurable B/R responses.
module tb_axi4lite_dist;

   logic           clk;
   logic           rst_i;
   logic           inport_awvalid_i, inport_awready_o;
   logic [31:0]    inport_awaddr_i;
   logic           inport_wvalid_i, inport_wready_o;
   logic [31:0]    inport_wdata_i;
   logic [3:0]     inport_wstrb_i;
   logic           inport_bvalid_o, inport_bready_i;
   logic [1:0]     inport_bresp_o;
   logic           inport_arvalid_i, inport_arready_o;
   logic [31:0]    inport_araddr_i;
   logic           inport_rvalid_o, inport_rready_i;
   logic [31:0]    inport_rdata_o;
   logic [1:0]     inport_rresp_o;
   logic [3:0]     outport_awvalid_o, outport_awready_i;
   logic [3:0]     outport_wvalid_o, outport_wready_i;
   logic [3:0]     outport_bvalid_i, outport_bready_o;
   logic [7:0]     outport_bresp_i;
   logic [3:0]     outport_arvalid_o, outport_arready_i;
   logic [3:0]     outport_rvalid_i, outport_rready_o;
   logic [127:0]   outport_rdata_i;
   logic [7:0]     outport_rresp_i;
   logic [31:0]    outport_awaddr_o, outport_wdata_o, outport_araddr_o;
   logic [3:0]     outport_wstrb_o;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   b_drv_cyc = 0;
   int   w_delay = 0;
   logic b_hold = 1'b0;
   int   onehot_bad = 0;
   int   cnt  [5][4] = '{default: 0};   // cycles each per-target bit was high: aw, w, ar, bready, rready
   int   base [5][4] = '{default: 0};
   logic any_out;

   assign any_out = |{inport_awready_o, inport_wready_o, inport_bvalid_o, inport_bresp_o,
                      inport_arready_o, inport_rvalid_o, inport_rdata_o, inport_rresp_o,
                      outport_awvalid_o, outport_wvalid_o, outport_bready_o, outport_arvalid_o,
                      outport_rready_o, outport_awaddr_o, outport_wdata_o, outport_wstrb_o,
                      outport_araddr_o};

   axi4lite_dist dut (
      .clk_i(clk), .rst_i(rst_i),
      .inport_awvalid_i(inport_awvalid_i), .inport_awready_o(inport_awready_o),
      .inport_awaddr_i(inport_awaddr_i),
      .inport_wvalid_i(inport_wvalid_i), .inport_wready_o(inport_wready_o),
      .inport_wdata_i(inport_wdata_i), .inport_wstrb_i(inport_wstrb_i),
      .inport_bvalid_o(inport_bvalid_o), .inport_bready_i(inport_bready_i),
      .inport_bresp_o(inport_bresp_o),
      .inport_arvalid_i(inport_arvalid_i), .inport_arready_o(inport_arready_o),
      .inport_araddr_i(inport_araddr_i),
      .inport_rvalid_o(inport_rvalid_o), .inport_rready_i(inport_rready_i),
      .inport_rdata_o(inport_rdata_o), .inport_rresp_o(inport_rresp_o),
      .outport_awvalid_o(outport_awvalid_o), .outport_awready_i(outport_awready_i),
      .outport_wvalid_o(outport_wvalid_o), .outport_wready_i(outport_wready_i),
      .outport_bvalid_i(outport_bvalid_i), .outport_bready_o(outport_bready_o),
      .outport_bresp_i(outport_bresp_i),
      .outport_arvalid_o(outport_arvalid_o), .outport_arready_i(outport_arready_i),
      .outport_rvalid_i(outport_rvalid_i), .outport_rready_o(outport_rready_o),
      .outport_rdata_i(outport_rdata_i), .outport_rresp_i(outport_rresp_i),
      .outport_awaddr_o(outport_awaddr_o), .outport_wdata_o(outport_wdata_o),
      .outport_wstrb_o(outport_wstrb_o), .outport_araddr_o(outport_araddr_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   // Per-target activity monitor (outputs only change on the rising edge or on reset).
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (outport_awvalid_o[i]) cnt[0][i]++;
            if (outport_wvalid_o[i])  cnt[1][i]++;
            if (outport_arvalid_o[i]) cnt[2][i]++;
            if (outport_bready_o[i])  cnt[3][i]++;
            if (outport_rready_o[i])  cnt[4][i]++;
         end
         if ($countones(outport_awvalid_o) > 1 || $countones(outport_wvalid_o) > 1 ||
             $countones(outport_arvalid_o) > 1 || $countones(outport_bready_o) > 1 ||
             $countones(outport_rready_o) > 1)
            onehot_bad++;
      end
   end

   // Target responder: AW/AR always ready, W ready after w_delay cycles, B/R answered one cycle after ready.
   initial begin
      int wc;
      wc = 0;
      outport_awready_i = 4'hF;
      outport_arready_i = 4'hF;
      outport_wready_i  = 4'h0;
      outport_bvalid_i  = 4'h0;
      outport_rvalid_i  = 4'h0;
      forever begin
         @(negedge clk);
         if (!rst_i) begin
            wc = 0;
            outport_wready_i = 4'h0;
            outport_bvalid_i = 4'h0;
            outport_rvalid_i = 4'h0;
         end else begin
            if (outport_wvalid_o != 4'h0) wc++;
            else wc = 0;
            outport_wready_i = (wc > w_delay) ? outport_wvalid_o : 4'h0;
            if (outport_bvalid_i != 4'h0) begin
               outport_bvalid_i = 4'h0;
            end else if (outport_bready_o != 4'h0 && !b_hold) begin
               outport_bvalid_i = outport_bready_o;
               b_drv_cyc = cyc;
            end
            if (outport_rvalid_i != 4'h0) outport_rvalid_i = 4'h0;
            else if (outport_rready_o != 4'h0) outport_rvalid_i = outport_rready_o;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      for (int k = 0; k < 5; k++)
         for (int i = 0; i < 4; i++)
            base[k][i] = cnt[k][i];
   endtask

   function automatic int dbit(input int k, input int i);
      return cnt[k][i] - base[k][i];
   endfunction

   function automatic int dsum(input int k);
      int s;
      s = 0;
      for (int i = 0; i < 4; i++) s += cnt[k][i] - base[k][i];
      return s;
   endfunction

   task automatic write_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input string tag);
      int k;
      inport_awaddr_i  = a;
      inport_wdata_i   = d;
      inport_wstrb_i   = s;
      inport_awvalid_i = 1'b1;
      inport_wvalid_i  = 1'b1;
      k = 0;
      while (!inport_awready_o && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_aw_w_accept"}, 32'({inport_awready_o, inport_wready_o}), 32'd3);
      @(negedge clk);
      inport_awvalid_i = 1'b0;
      inport_wvalid_i  = 1'b0;
      check({tag, "_awready_pulse"}, 32'({inport_awready_o, inport_wready_o}), 32'd0);
   endtask

   task automatic read_req(input logic [31:0] a, input string tag);
      int k;
      inport_araddr_i  = a;
      inport_arvalid_i = 1'b1;
      k = 0;
      while (!inport_arready_o && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_ar_accept"}, 32'(inport_arready_o), 32'd1);
      @(negedge clk);
      inport_arvalid_i = 1'b0;
      check({tag, "_arready_pulse"}, 32'(inport_arready_o), 32'd0);
   endtask

   task automatic wait_b(input string tag, input logic [1:0] exp_resp);
      int k;
      k = 0;
      while (!inport_bvalid_o && k < 50) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_bvalid"}, 32'(inport_bvalid_o), 32'd1);
      check({tag, "_bresp"}, 32'(inport_bresp_o), 32'(exp_resp));
   endtask

   task automatic b_ack(input string tag);
      inport_bready_i = 1'b1;
      @(negedge clk);
      inport_bready_i = 1'b0;
      check({tag, "_bvalid_drop"}, 32'(inport_bvalid_o), 32'd0);
   endtask

   task automatic wait_r(input string tag, input logic [31:0] exp_d, input logic [1:0] exp_r,
                         input int hold);
      int k;
      k = 0;
      while (!inport_rvalid_o && k < 50) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_rvalid"}, 32'(inport_rvalid_o), 32'd1);
      check({tag, "_rdata"}, inport_rdata_o, exp_d);
      check({tag, "_rresp"}, 32'(inport_rresp_o), 32'(exp_r));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_rvalid_held"}, 32'(inport_rvalid_o), 32'd1);
         check({tag, "_rdata_held"}, inport_rdata_o, exp_d);
      end
      inport_rready_i = 1'b1;
      @(negedge clk);
      inport_rready_i = 1'b0;
      check({tag, "_rvalid_drop"}, 32'(inport_rvalid_o), 32'd0);
   endtask

   initial begin
      int k;
      rst_i = 1'b0;
      inport_awvalid_i = 1'b0; inport_awaddr_i = 32'h0; inport_wvalid_i = 1'b0;
      inport_wdata_i = 32'h0;  inport_wstrb_i = 4'h0;  inport_bready_i = 1'b0;
      inport_arvalid_i = 1'b0; inport_araddr_i = 32'h0; inport_rready_i = 1'b0;
      outport_bresp_i = 8'h00; outport_rdata_i = 128'h0; outport_rresp_i = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'(any_out), 32'd0);
      rst_i = 1'b1;
      @(negedge clk);

      // T1: write to target 1; AW alone must not be accepted
      outport_bresp_i = 8'b11_10_00_01;
      snap();
      inport_awaddr_i  = 32'h9100_0010;
      inport_awvalid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t1_aw_alone", 32'(inport_awready_o), 32'd0);
      end
      write_req(32'h9100_0010, 32'hDEAD_BEEF, 4'hF, "t1");
      check("t1_awvalid", 32'(outport_awvalid_o), 32'h2);
      check("t1_wvalid", 32'(outport_wvalid_o), 32'h2);
      check("t1_awaddr", outport_awaddr_o, 32'h9100_0010);
      check("t1_wdata", outport_wdata_o, 32'hDEAD_BEEF);
      check("t1_wstrb", 32'(outport_wstrb_o), 32'hF);
      wait_b("t1", 2'b00);
      check("t1_b_latency", cyc - b_drv_cyc, 32'd1);
      b_ack("t1");
      check("t1_aw_t1_cycles", dbit(0, 1), 32'd1);
      check("t1_aw_total", dsum(0), 32'd1);
      check("t1_w_total", dsum(1), 32'd1);
      check("t1_bready_t1", dbit(3, 1), 32'd1);
      check("t1_bready_total", dsum(3), 32'd1);

      // T2: read from target 3
      outport_rdata_i = {32'h1234_5678, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
      outport_rresp_i = 8'b00_11_10_01;
      snap();
      read_req(32'h9300_0004, "t2");
      check("t2_arvalid", 32'(outport_arvalid_o), 32'h8);
      check("t2_araddr", outport_araddr_o, 32'h9300_0004);
      wait_r("t2", 32'h1234_5678, 2'b00, 0);
      check("t2_ar_t3", dbit(2, 3), 32'd1);
      check("t2_ar_total", dsum(2), 32'd1);
      check("t2_rready_total", dsum(4), 32'd1);

      // T3: unmapped read (select 5) and unmapped write (top nibble 8)
      snap();
      read_req(32'h9500_0000, "t3r");
      wait_r("t3r", 32'h0, 2'b11, 0);
      write_req(32'h8000_0000, 32'h1111_2222, 4'hF, "t3w");
      wait_b("t3w", 2'b11);
      b_ack("t3w");
      check("t3_no_target_activity", dsum(0) + dsum(1) + dsum(2) + dsum(3) + dsum(4), 32'd0);
      check("t3_araddr_hold", outport_araddr_o, 32'h9300_0004);
      check("t3_awaddr_hold", outport_awaddr_o, 32'h9100_0010);

      // T4: target 0 delays wready by 5 cycles, responds SLVERR
      w_delay = 5;
      outport_bresp_i = 8'b01_00_11_10;
      snap();
      write_req(32'h9000_0100, 32'h0BAD_CAFE, 4'h3, "t4");
      wait_b("t4", 2'b10);
      b_ack("t4");
      check("t4_aw_cycles", dbit(0, 0), 32'd1);
      check("t4_w_cycles", dbit(1, 0), 32'd6);
      check("t4_w_total", dsum(1), 32'd6);
      w_delay = 0;

      // T5: concurrent read and write to target 2, rready held low 3 cycles
      outport_bresp_i = 8'b11_00_10_11;
      outport_rdata_i = {32'h1111_1111, 32'hCAFE_F00D, 32'h2222_2222, 32'h3333_3333};
      outport_rresp_i = 8'b11_01_10_11;
      snap();
      fork
         begin
            write_req(32'h9200_0008, 32'h0102_0304, 4'hF, "t5w");
            wait_b("t5w", 2'b00);
            b_ack("t5w");
         end
         begin
            read_req(32'h9200_0008, "t5r");
            wait_r("t5r", 32'hCAFE_F00D, 2'b01, 3);
         end
      join
      check("t5_aw_t2", dbit(0, 2), 32'd1);
      check("t5_ar_t2", dbit(2, 2), 32'd1);
      check("t5_aw_total", dsum(0), 32'd1);
      check("t5_ar_total", dsum(2), 32'd1);

      // T6: reset while waiting for B, then a fresh write
      b_hold = 1'b1;
      write_req(32'h9000_0040, 32'h5555_AAAA, 4'hF, "t6");
      k = 0;
      while (outport_bready_o == 4'h0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("t6_in_wait", 32'(outport_bready_o), 32'h1);
      #2;
      rst_i = 1'b0;
      #1;
      check("t6_async_reset", 32'(any_out), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("t6_reset_held", 32'(any_out), 32'd0);
      rst_i = 1'b1;
      b_hold = 1'b0;
      outport_bresp_i = 8'b01_00_00_10;
      @(negedge clk);
      @(negedge clk);
      check("t6_no_stale_b", 32'(inport_bvalid_o), 32'd0);
      write_req(32'h9300_0020, 32'h0A0B_0C0D, 4'hC, "t6b");
      check("t6b_awvalid", 32'(outport_awvalid_o), 32'h8);
      wait_b("t6b", 2'b01);
      b_ack("t6b");

      check("onehot_vectors", onehot_bad, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
